// File: rtl/decomp_pipe_ctrl_pkg.sv
// Shared definitions for the decomposition pipeline controller.
// Holds the shared parameter defines (chain depth, tag width, delivered-frame
// counter width), their typed localparam mirrors, and the controller FSM
// state type.
`ifndef DECOMP_LAT
`define DECOMP_LAT 8
`endif
`ifndef DECOMP_TAG_WL
`define DECOMP_TAG_WL 4
`endif
`ifndef DECOMP_CNT_WL
`define DECOMP_CNT_WL 16
`endif

package decomp_pipe_ctrl_pkg;

  localparam int unsigned DefLat  = `DECOMP_LAT;
  localparam int unsigned DefTagW = `DECOMP_TAG_WL;
  localparam int unsigned DefCntW = `DECOMP_CNT_WL;

  // RUN accepts frames, DRAIN empties the chain, DONE flags the end of a drain.
  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/decomp_valid_pipe.sv
// Valid/tag shift register running alongside the decomposition chain.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   en_i           global advance enable (chain pipe_en)
//   valid_i        valid bit entering stage 0 (chain load enable)
//   tag_i          tag entering stage 0
//   out_valid_o    valid bit of the last stage
//   out_tag_o      tag of the last stage
// All stages move together; nothing collapses bubbles.
module decomp_valid_pipe #(
  parameter int unsigned LAT   = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  output logic [TAG_W-1:0] out_tag_o
);

  logic [LAT-1:0]   valid_q;
  logic [TAG_W-1:0] tag_q [LAT];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else if (en_i) begin
      valid_q  <= {valid_q[LAT-2:0], valid_i};
      tag_q[0] <= tag_i;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[LAT-1];
  assign out_tag_o   = tag_q[LAT-1];

endmodule

// File: rtl/decomp_pipe_ctrl.sv
// Flow controller for the QR/channel decomposition chain feeding K-best search.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   in_valid/in_ready   upstream frame handshake
//   load_en             capture enable for the chain input register
//   pipe_en             global advance enable for all chain stages
//   out_valid/out_ready downstream handshake, out_tag = tag at chain output
//   flush_req           stop intake and drain; flush_done pulses when empty
//   busy, occupancy     frames in flight
//   frame_cnt           frames delivered since reset (wrapping)
module decomp_pipe_ctrl
  import decomp_pipe_ctrl_pkg::*;
#(
  parameter int unsigned LAT   = DefLat,
  parameter int unsigned TAG_W = DefTagW,
  parameter int unsigned CNT_W = DefCntW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     load_en,
  output logic                     pipe_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAG_W-1:0]         out_tag,
  input  logic                     flush_req,
  output logic                     flush_done,
  output logic                     busy,
  output logic [$clog2(LAT+1)-1:0] occupancy,
  output logic [CNT_W-1:0]         frame_cnt
);

  localparam int unsigned OccW = $clog2(LAT + 1);

  state_e           state_q;
  logic             flush_done_q;
  logic [TAG_W-1:0] next_tag_q, next_tag_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             deliver;

  // Handshake. The chain only stalls when its output is occupied and refused.
  assign pipe_en  = ~out_valid | out_ready;
  assign in_ready = pipe_en & (state_q == StRun);
  // A flush request squashes the accept in its own cycle; the registered
  // DRAIN state blocks every later one.
  assign load_en  = in_valid & in_ready & ~flush_req;
  assign deliver  = out_valid & out_ready;

  decomp_valid_pipe #(
    .LAT  (LAT),
    .TAG_W(TAG_W)
  ) u_valid_pipe (
    .clk_i      (clk),
    .rst_ni     (rst),
    .en_i       (pipe_en),
    .valid_i    (load_en),
    .tag_i      (next_tag_q),
    .out_valid_o(out_valid),
    .out_tag_o  (out_tag)
  );

  always_comb begin
    occ_d = occ_q;
    if (load_en && !deliver) begin
      occ_d = occ_q + 1'b1;
    end else if (deliver && !load_en) begin
      occ_d = occ_q - 1'b1;
    end
    next_tag_d  = load_en ? next_tag_q + 1'b1 : next_tag_q;
    frame_cnt_d = deliver ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_q       <= '0;
      next_tag_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      occ_q       <= occ_d;
      next_tag_q  <= next_tag_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Flush FSM. flush_done is registered on the DRAIN->DONE transition so it
  // is high exactly while the state is DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (flush_req) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (occ_q == '0) begin
            state_q      <= StDone;
            flush_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

  assign flush_done = flush_done_q;
  assign busy       = (occ_q != '0);
  assign occupancy  = occ_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: doc/decomp_pipe_ctrl.md
DECOMP_PIPE_CTRL -- requirements
Module: decomp_pipe_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 8, meaning pipeline depth in cycles of the decomposition chain (input register plus stages); legal range 2..16.
REQ-002 SHALL have parameter TAG_W, default 4, meaning frame tag width.
REQ-003 SHALL have parameter CNT_W, default 16, meaning completed-frame counter width.
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream has a frame (H, Y, order, norm) ready.
REQ-007 in_ready  output  1  controller accepts a frame this cycle.
REQ-008 load_en  output  1  capture enable for the chain input register; equals in_valid & in_ready.
REQ-009 pipe_en  output  1  global advance enable for every stage register of the chain.
REQ-010 out_valid  output  1  chain output holds a valid decomposed frame.
REQ-011 out_ready  input  1  downstream (K-best search) accepts the frame.
REQ-012 out_tag  output  TAG_W  tag of the frame at the chain output.
REQ-013 flush_req  input  1  request to stop intake and drain the chain.
REQ-014 flush_done  output  1  one-cycle pulse when a drain completes.
REQ-015 busy  output  1  at least one frame in flight.
REQ-016 occupancy  output  $clog2(LAT+1)  number of frames in flight.
REQ-017 frame_cnt  output  CNT_W  frames delivered downstream since reset, wraps modulo 2^CNT_W.

Function
REQ-018 SHALL keep a LAT-bit valid shift register v[0..LAT-1] and a parallel TAG_W-bit tag shift register.
REQ-019 SHALL drive pipe_en = ~v[LAT-1] | out_ready, combinationally; the chain has no bubble collapsing.
REQ-020 SHALL drive out_valid = v[LAT-1] and out_tag = tag[LAT-1].
REQ-021 When pipe_en=1, SHALL shift v and tag one position; v[0] <= load_en, tag[0] <= next_tag; when pipe_en=0, v and tag SHALL hold.
REQ-022 SHALL drive in_ready = pipe_en & (state==RUN).
REQ-023 A frame accepted in cycle c with no stall SHALL raise out_valid in cycle c+LAT; each stall cycle adds exactly one cycle.
REQ-024 next_tag SHALL increment by 1 (wrap at 2^TAG_W) on every load_en.
REQ-025 occupancy SHALL +1 on load_en only, -1 on out_valid&out_ready only, unchanged when both or neither occur; busy = (occupancy!=0).
REQ-026 frame_cnt SHALL increment on every out_valid&out_ready, wrapping from all-ones to 0.
REQ-027 FSM states RUN, DRAIN, DONE; reset state RUN.
REQ-028 RUN->DRAIN when flush_req=1; the frame offered in the same cycle SHALL NOT be accepted (in_ready already low is not required; the registered state change blocks it from the next cycle, and load_en in the flush_req cycle SHALL be forced 0).
REQ-029 DRAIN: in_ready=0; in-flight frames complete normally; DRAIN->DONE when occupancy==0 (or next cycle if already 0).
REQ-030 DONE: flush_done=1 for exactly one cycle; DONE->RUN unconditionally.
REQ-031 flush_req while in DRAIN or DONE SHALL be ignored.

Reset
REQ-032 On rst=0, v, tag register, next_tag, occupancy, frame_cnt SHALL clear to 0 and state to RUN, asynchronously.
REQ-033 Outputs during reset: in_ready=1 only if out_ready-independent pipe_en=1 (v empty), out_valid=0, out_tag=0, flush_done=0, busy=0, occupancy=0, frame_cnt=0.
REQ-034 Reset mid-operation SHALL discard all in-flight frames with no out_valid emitted for them.

Structure
REQ-035 LAT default, TAG_W and CNT_W defaults SHALL be defines in the shared parameters.v include (DECOMP_LAT, DECOMP_TAG_WL, DECOMP_CNT_WL).
REQ-036 The valid/tag shift register with enable SHALL be one sub-module, decomp_valid_pipe; FSM, counters and handshake logic remain in the top.

Verification
REQ-037 Single frame, out_ready=1: in_valid 1 cycle at c=5 -> out_valid high only in cycle 13, out_tag=0, frame_cnt=1.
REQ-038 Back-to-back 20 frames, out_ready=1 -> in_ready never drops, outputs in cycles 13..32 with tags 0..15,0..3, occupancy peaks at 8.
REQ-039 Full chain, out_ready=0 for 5 cycles -> pipe_en=0, in_ready=0, v and out_tag frozen; resumes with no loss or duplication.
REQ-040 flush_req with 3 frames in flight and in_valid held 1 -> no new accept, 3 frames delivered, flush_done pulses once the cycle after occupancy reaches 0, then in_ready returns.
REQ-041 rst low for 1 cycle with 4 frames in flight -> all outputs at reset values, no stale out_valid afterward.
REQ-042 Preload frame_cnt near wrap (65535 deliveries, or forced) -> next delivery yields 0.
